// File: rtl/adc_current_scaler_pkg.sv
// Shared constants, state encoding and saturation helper for the current-scaling path.
package adc_pkg;

    localparam int ADC_W = 12;
    localparam int I_W   = 16;
    localparam int I_MAX = 32767;

    localparam logic [ADC_W-1:0] OFFSET_RST = 12'd2048;

    typedef enum logic {
        CAL = 1'b0,
        RUN = 1'b1
    } state_e;

    // Symmetric clamp so the magnitude of any result always fits in I_W-1 bits.
    function automatic logic signed [I_W-1:0] sat16(input logic signed [31:0] value);
        logic signed [I_W-1:0] result;
        if (value > I_MAX) begin
            result = I_W'(I_MAX);
        end else if (value < -I_MAX) begin
            result = I_W'(-I_MAX);
        end else begin
            result = value[I_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/adc_offset_cal.sv
// Zero-current offset calibration: averages 2^CAL_SHIFT codes and publishes the mean.
module adc_offset_cal
    import adc_pkg::*;
#(
    parameter int CAL_SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] code,
    output logic [ADC_W-1:0] offset,
    output logic             done_pulse
);

    localparam int ACC_W = ADC_W + CAL_SHIFT;
    localparam int CNT_W = CAL_SHIFT + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((2 ** CAL_SHIFT) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt;

    assign acc_sum    = acc + ACC_W'(code);
    assign done_pulse = sample_valid && !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            offset <= OFFSET_RST;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (sample_valid) begin
            if (cnt == LAST) begin
                // Truncating divide by the sample count.
                offset <= acc_sum[ACC_W-1:CAL_SHIFT];
                acc    <= '0;
                cnt    <= '0;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_current_scaler.sv
// Converts unipolar ADC codes into signed, gain-scaled, saturated phase current
// with startup offset calibration and a latched overcurrent monitor.
module adc_current_scaler
    import adc_pkg::*;
#(
    parameter int                 CAL_SHIFT  = 6,
    parameter logic signed [15:0] GAIN       = 16'sd256,
    parameter int                 GAIN_SHIFT = 8,
    parameter logic [15:0]        OC_LIMIT   = 16'd30000,
    parameter int                 OC_COUNT   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           adc_data,
    input  logic                  adc_enable,
    input  logic                  cal_start,
    input  logic                  fault_clr,
    output logic signed [I_W-1:0] i_out,
    output logic                  i_valid,
    output logic                  cal_done,
    output logic [ADC_W-1:0]      offset,
    output logic                  oc_fault,
    output state_e                state_dbg
);

    // Handshake: a 0->1 transition of adc_enable delivers one sample; i_valid is a
    // one-cycle pulse qualifying i_out. There is no back-pressure in either direction.

    localparam int DIFF_W = ADC_W + 1;
    localparam int PROD_W = DIFF_W + 16;
    localparam int OC_CW  = $clog2(OC_COUNT + 1);
    localparam logic [OC_CW-1:0] OC_MAX = OC_CW'(OC_COUNT);

    state_e                    state;
    logic                      en_d;
    logic                      new_sample;
    logic                      cal_done_pulse;
    logic                      unused_adc_hi;

    logic                      s1_valid;
    logic [ADC_W-1:0]          s1_code;
    logic                      s2_valid;
    logic signed [DIFF_W-1:0]  s2_diff;
    logic                      s3_valid;
    logic signed [PROD_W-1:0]  s3_prod;
    logic signed [PROD_W-1:0]  shifted;

    logic [OC_CW-1:0]          oc_cnt;
    logic [OC_CW-1:0]          oc_next;
    logic [I_W-1:0]            abs_i;
    logic                      over;
    logic                      oc_eval;
    logic                      trip;

    assign unused_adc_hi = ^adc_data[15:12];
    assign new_sample    = adc_enable & ~en_d;
    assign state_dbg     = state;

    adc_offset_cal #(
        .CAL_SHIFT (CAL_SHIFT)
    ) u_offset_cal (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (cal_start),
        .sample_valid (s1_valid && (state == CAL)),
        .code         (s1_code),
        .offset       (offset),
        .done_pulse   (cal_done_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CAL;
            cal_done <= 1'b0;
        end else if (cal_start) begin
            state    <= CAL;
            cal_done <= 1'b0;
        end else begin
            case (state)
                CAL: begin
                    if (cal_done_pulse) begin
                        state    <= RUN;
                        cal_done <= 1'b1;
                    end
                end
                RUN: begin
                    state    <= RUN;
                    cal_done <= 1'b1;
                end
                default: begin
                    state    <= CAL;
                    cal_done <= 1'b0;
                end
            endcase
        end
    end

    assign shifted = s3_prod >>> GAIN_SHIFT;

    // Stage 1 always captures a new sample (it may be a calibration sample);
    // later stages only advance in RUN and are flushed by cal_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d     <= 1'b0;
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s2_valid <= 1'b0;
            s2_diff  <= '0;
            s3_valid <= 1'b0;
            s3_prod  <= '0;
            i_valid  <= 1'b0;
            i_out    <= '0;
        end else begin
            en_d     <= adc_enable;
            s1_valid <= new_sample;
            if (new_sample) begin
                s1_code <= adc_data[ADC_W-1:0];
            end
            s2_valid <= s1_valid && (state == RUN) && !cal_start;
            if (s1_valid) begin
                s2_diff <= $signed({1'b0, s1_code}) - $signed({1'b0, offset});
            end
            s3_valid <= s2_valid && !cal_start;
            if (s2_valid) begin
                s3_prod <= PROD_W'(s2_diff) * PROD_W'(GAIN);
            end
            i_valid <= s3_valid && !cal_start;
            if (s3_valid) begin
                i_out <= sat16(32'(shifted));
            end
        end
    end

    assign abs_i   = i_out[I_W-1] ? I_W'(-i_out) : I_W'(i_out);
    assign over    = abs_i > OC_LIMIT;
    assign oc_eval = i_valid && (state == RUN);

    always_comb begin
        oc_next = '0;
        if (over) begin
            oc_next = (oc_cnt == OC_MAX) ? oc_cnt : oc_cnt + 1'b1;
        end
        trip = oc_eval && over && (oc_next == OC_MAX);
    end

    // A trip on the same edge as fault_clr wins, so a live fault is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc_cnt   <= '0;
            oc_fault <= 1'b0;
        end else if (trip) begin
            oc_cnt   <= oc_next;
            oc_fault <= 1'b1;
        end else if (fault_clr) begin
            oc_cnt   <= '0;
            oc_fault <= 1'b0;
        end else if (oc_eval) begin
            oc_cnt <= oc_next;
        end
    end

endmodule

// File: tb/tb_adc_current_scaler.sv
// Three scaler instances (default, high gain, low overcurrent limit) share one
// stimulus stream; a reference model predicts outputs into per-instance queues.
module tb_adc_current_scaler;
    import adc_pkg::*;

    localparam int N_DUT = 3;
    localparam int CAL_N = 64;
    localparam int OC_N  = 3;
    localparam int BIG   = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] adc_data = '0;
    logic        adc_enable = 1'b0;
    logic        cal_start = 1'b0;
    logic        fault_clr = 1'b0;

    logic signed [15:0] i_out     [N_DUT];
    logic               i_valid   [N_DUT];
    logic               cal_done  [N_DUT];
    logic [11:0]        offset    [N_DUT];
    logic               oc_fault  [N_DUT];
    state_e             state_dbg [N_DUT];

    int gain_tab [N_DUT] = '{256, 32767, 256};
    int lim_tab  [N_DUT] = '{30000, 30000, 1000};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    adc_current_scaler u_dut0 (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_enable(adc_enable),
        .cal_start(cal_start), .fault_clr(fault_clr), .i_out(i_out[0]),
        .i_valid(i_valid[0]), .cal_done(cal_done[0]), .offset(offset[0]),
        .oc_fault(oc_fault[0]), .state_dbg(state_dbg[0])
    );

    adc_current_scaler #(.GAIN(16'sd32767)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_enable(adc_enable),
        .cal_start(cal_start), .fault_clr(fault_clr), .i_out(i_out[1]),
        .i_valid(i_valid[1]), .cal_done(cal_done[1]), .offset(offset[1]),
        .oc_fault(oc_fault[1]), .state_dbg(state_dbg[1])
    );

    adc_current_scaler #(.OC_LIMIT(16'd1000), .OC_COUNT(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_enable(adc_enable),
        .cal_start(cal_start), .fault_clr(fault_clr), .i_out(i_out[2]),
        .i_valid(i_valid[2]), .cal_done(cal_done[2]), .offset(offset[2]),
        .oc_fault(oc_fault[2]), .state_dbg(state_dbg[2])
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic signed [15:0] exp_q     [N_DUT][$];
    int                 exp_cyc_q [N_DUT][$];

    bit mode_run;
    int cal_sum, cal_cnt;
    int off_old, off_new, off_at;
    int run_from, stop_at;
    bit exp_fault [N_DUT];
    int ocnt      [N_DUT];

    task automatic check(input string name, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0d want=%0d (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    function automatic int model_i(input int code, input int off, input int gain);
        longint p;
        p = longint'(code - off) * gain;
        p = p >>> 8;
        if (p > 32767) p = 32767;
        if (p < -32767) p = -32767;
        return int'(p);
    endfunction

    task automatic model_reset();
        mode_run = 1'b0;
        cal_sum  = 0;
        cal_cnt  = 0;
        off_old  = 2048;
        off_new  = 2048;
        off_at   = 0;
        run_from = BIG;
        stop_at  = BIG;
        for (int k = 0; k < N_DUT; k++) begin
            exp_fault[k] = 1'b0;
            ocnt[k]      = 0;
            exp_q[k].delete();
            exp_cyc_q[k].delete();
        end
    endtask

    task automatic model_cal_start(input int now);
        mode_run = 1'b0;
        cal_sum  = 0;
        cal_cnt  = 0;
        stop_at  = now + 1;
        for (int k = 0; k < N_DUT; k++) begin
            while (exp_cyc_q[k].size() > 0 && exp_cyc_q[k][$] > now) begin
                void'(exp_q[k].pop_back());
                void'(exp_cyc_q[k].pop_back());
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // cal_dly / clr_dly: cycles after the sample drive at which to pulse (0 = none).
    task automatic send_sample(input int code, input int gap, input int cal_dly, input int clr_dly);
        int n0;
        int len;
        @(posedge clk); #2;
        adc_data   = {4'($urandom_range(0, 15)), 12'(code)};
        adc_enable = 1'b1;
        n0 = cyc;
        if (!mode_run) begin
            cal_sum += code;
            cal_cnt++;
            if (cal_cnt == CAL_N) begin
                off_old  = off_new;
                off_new  = cal_sum / CAL_N;
                off_at   = n0 + 2;
                run_from = n0 + 2;
                stop_at  = BIG;
                mode_run = 1'b1;
            end
        end else begin
            for (int k = 0; k < N_DUT; k++) begin
                exp_q[k].push_back(16'(model_i(code, off_new, gain_tab[k])));
                exp_cyc_q[k].push_back(n0 + 4);
            end
        end
        len = 2 + gap;
        if (cal_dly >= len) len = cal_dly + 1;
        if (clr_dly >= len) len = clr_dly + 1;
        for (int d = 1; d < len; d++) begin
            @(posedge clk); #2;
            adc_enable = 1'b0;
            cal_start  = (d == cal_dly);
            fault_clr  = (d == clr_dly);
            if (d == cal_dly) model_cal_start(cyc);
        end
        @(posedge clk); #2;
        cal_start = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic check_reset_values();
        for (int k = 0; k < N_DUT; k++) begin
            check("rst_i_out", k, int'(i_out[k]), 0);
            check("rst_i_valid", k, int'(i_valid[k]), 0);
            check("rst_cal_done", k, int'(cal_done[k]), 0);
            check("rst_oc_fault", k, int'(oc_fault[k]), 0);
            check("rst_offset", k, int'(offset[k]), 2048);
            check("rst_state", k, int'(state_dbg[k] == RUN), 0);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < N_DUT; k++) begin
                logic signed [15:0] v;
                int  c;
                int  mag;
                bit  have;
                bit  trip;
                bit  exp_done;
                have = 1'b0;
                trip = 1'b0;
                v = '0;
                exp_done = (cyc >= run_from) && (cyc < stop_at);
                check("oc_fault", k, int'(oc_fault[k]), int'(exp_fault[k]));
                check("cal_done", k, int'(cal_done[k]), int'(exp_done));
                check("state_run", k, int'(state_dbg[k] == RUN), int'(exp_done));
                check("offset", k, int'(offset[k]), (cyc >= off_at) ? off_new : off_old);
                if (i_valid[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check("unexpected_i_valid", k, 1, 0);
                    end else begin
                        v = exp_q[k].pop_front();
                        c = exp_cyc_q[k].pop_front();
                        check("i_out", k, int'(i_out[k]), int'(v));
                        check("i_valid_cycle", k, cyc, c);
                        have = 1'b1;
                    end
                end
                if (have) begin
                    mag = (v < 0) ? -int'(v) : int'(v);
                    if (mag > lim_tab[k]) ocnt[k] = (ocnt[k] < OC_N) ? ocnt[k] + 1 : OC_N;
                    else ocnt[k] = 0;
                    trip = (ocnt[k] == OC_N);
                end
                if (trip) begin
                    exp_fault[k] = 1'b1;
                end else if (fault_clr) begin
                    exp_fault[k] = 1'b0;
                    ocnt[k]      = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int seq [6];
        seq = '{3200, 3200, 2500, 3200, 3200, 3200};
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_values();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        // Startup calibration at 2000.
        for (int i = 0; i < CAL_N; i++) send_sample(2000, $urandom_range(0, 1), 0, 0);

        // Latency, sign and saturation.
        send_sample(2100, 3, 0, 0);
        send_sample(4095, 1, 0, 0);
        send_sample(0, 1, 0, 0);
        send_sample(2000, 1, 0, 4);

        // Overcurrent sequence, then fault_clr racing a tripping sample, then a real clear.
        foreach (seq[i]) send_sample(seq[i], $urandom_range(0, 2), 0, 0);
        send_sample(3200, 2, 0, 4);
        send_sample(2500, 2, 0, 4);

        // Randomized run traffic with occasional fault clears.
        for (int i = 0; i < 40; i++) begin
            send_sample($urandom_range(0, 4095), $urandom_range(0, 3), 0,
                        ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5) : 0);
        end

        // Recalibration aborting an in-flight sample.
        send_sample(3000, 2, 1, 0);
        for (int i = 0; i < CAL_N; i++) send_sample(1500, $urandom_range(0, 1), 0, 0);
        for (int i = 0; i < 8; i++) send_sample($urandom_range(0, 4095), $urandom_range(0, 2), 0, 0);

        // Asynchronous reset while a sample sits in stage 2.
        send_sample(3900, 3, 0, 0);
        @(posedge clk); #2;
        adc_data   = 16'd3500;
        adc_enable = 1'b1;
        @(posedge clk); #2;
        adc_enable = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        model_reset();
        #1 check_reset_values();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Calibrate on noisy codes and run a few more samples.
        for (int i = 0; i < CAL_N; i++) send_sample($urandom_range(1800, 2300), $urandom_range(0, 1), 0, 0);
        for (int i = 0; i < 10; i++) send_sample($urandom_range(0, 4095), $urandom_range(0, 2), 0, 0);

        repeat (8) @(posedge clk);
        #2;
        for (int k = 0; k < N_DUT; k++) check("drain", k, exp_q[k].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_current_scaler.md
# adc_current_scaler

Downstream consumer of the SPI ADC reader in the current-measurement path. It takes each 12-bit unipolar conversion result and converts it to a signed, gain-scaled, saturated phase-current value for the vector-control loop. A startup (and on-demand) calibration phase averages samples to find the zero-current offset. An overcurrent monitor latches a fault after consecutive over-limit samples.

## Interface
- CAL_SHIFT, 6: log2 of the number of samples averaged during calibration (64).
- GAIN, 16'sd256: signed 16-bit gain multiplier.
- GAIN_SHIFT, 8: arithmetic right shift applied after the multiply.
- OC_LIMIT, 16'd30000: overcurrent threshold on |i_out|, unsigned, ≤32767.
- OC_COUNT, 3: number of consecutive over-limit samples that trips the fault (≥1).
- clk  in  1  system clock; single clock domain, shared with the ADC reader.
- rst_n  in  1  asynchronous, active-low reset.
- adc_data  in  16  ADC result; only [11:0] is used, [15:12] is ignored.
- adc_enable  in  1  ADC result-ready level; a 0→1 transition marks a new sample.
- cal_start  in  1  1-cycle pulse that restarts calibration.
- fault_clr  in  1  1-cycle pulse that clears oc_fault and the overcurrent counter.
- i_out  out  16  signed scaled current; holds its value between samples.
- i_valid  out  1  1-cycle pulse when i_out is updated.
- cal_done  out  1  high while in RUN.
- offset  out  12  current zero-current offset.
- oc_fault  out  1  latched overcurrent fault.

## Operation
- Reset values:
  - i_out=0, i_valid=0, cal_done=0, oc_fault=0.
  - offset=12'd2048.
  - Overcurrent counter 0, accumulator 0, pipeline valid bits 0.
  - State CAL.
- Edge detect: register adc_enable as en_d. A sample is new when adc_enable & ~en_d. The sample edge latches adc_data[11:0] into stage 1.
- State CAL:
  - Each new sample adds its code to a (12+CAL_SHIFT)-bit accumulator and increments a sample counter.
  - On the 2^CAL_SHIFT-th sample: offset ← acc >> CAL_SHIFT (truncating), then go to RUN and set cal_done.
  - No i_valid is produced. offset keeps its previous value until the update.
- State RUN: 3-stage pipeline.
  - S1: code register.
  - S2: diff = code − offset, 13-bit signed.
  - S3: prod = diff × GAIN, 29-bit signed.
  - Output: shifted = prod >>> GAIN_SHIFT, saturated to [−32767, +32767] (symmetric, so |i_out| always fits), then registered to i_out and i_valid pulses.
- cal_start in any state:
  - Clear accumulator and counter, go to CAL, drop cal_done the next cycle.
  - Invalidate all in-flight pipeline stages (no i_valid for them).
  - A new sample on the same edge counts as the first calibration sample.
- Overcurrent (RUN only, evaluated on each i_valid):
  - If |i_out| > OC_LIMIT, the counter increments, saturating at OC_COUNT. Otherwise the counter clears.
  - When the counter reaches OC_COUNT, oc_fault sets and stays set.
- fault_clr clears oc_fault and the counter. If it coincides with a tripping sample, the trip wins (oc_fault stays 1).
- oc_fault is unaffected by cal_start; only rst_n and fault_clr clear it.

## Timing
- Let edge E be the first rising clk edge that samples adc_enable=1 after it was 0.
- Stage updates:
  - S1 loads at E.
  - S2 at E+1.
  - S3 at E+2.
  - i_out/i_valid at E+3; i_valid is high for exactly one cycle.
- oc_fault rises at the same edge that produces the tripping i_valid's evaluation, E+4. Overcurrent logic uses the registered i_out.
- Calibration completion: offset and cal_done update at E+1 of the final calibration sample.
- The pipeline accepts one sample per cycle. No back-pressure is needed: ADC samples are ≥2 cycles apart because adc_enable must return low.
- An asynchronous rst_n assertion mid-pipeline or mid-calibration forces all reset values immediately. Operation resumes in CAL on the first edge after deassertion.

## Structure
- Shared package adc_pkg:
  - Constants ADC_W=12, I_W=16, I_MAX=32767.
  - State enum {CAL, RUN}.
  - Function sat16 (signed saturate to ±I_MAX).
- Sub-module adc_offset_cal holds the accumulator, sample counter and offset register, with outputs offset and done_pulse.
- The pipeline and overcurrent logic stay in the top module.

## Test plan
1. Calibration: after reset, 64 samples of code 2000 → offset=2000 and cal_done=1 at E+1 of the 64th sample; no i_valid during CAL.
2. Latency: in RUN with offset=2000 and defaults, code 2100 → i_out=100, i_valid high exactly at E+3 for one cycle.
3. Sign and saturation:
   - GAIN=16'sd32767, offset=2000.
   - Code 4095 → i_out=+32767.
   - Code 0 → i_out=−32767.
   - Code 2000 → i_out=0.
4. Overcurrent: OC_LIMIT=1000, OC_COUNT=3, defaults, offset=2000.
   - Codes 3200, 3200, 2500, 3200, 3200, 3200 → oc_fault=0 until after the 6th sample, 1 after.
   - fault_clr concurrent with a tripping sample → oc_fault stays 1.
5. Recalibration:
   - cal_start one cycle after a RUN sample edge → no i_valid for that sample, cal_done low next cycle.
   - offset unchanged until 64 new samples of 1500 complete, then offset=1500.
6. Reset: rst_n low during S2 of a sample → all outputs at reset values asynchronously, offset=2048, no i_valid after release.
